// File: rtl/dc_ex_issue_reg.sv
// Decode-to-execute issue register for a four-slot bundle (ixu1, ixu2, lsu, bru).
// It inserts bubbles on stall and flush, and keeps a saturating count of stall cycles.
module dc_ex_issue_reg #(
  parameter int                 INSTR_W   = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013,
  parameter int                 CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_in,
  input  logic               flush_in,
  input  logic               dc_valid_in,
  input  logic [INSTR_W-1:0] dc_ixu1_instr_in,
  input  logic [INSTR_W-1:0] dc_ixu2_instr_in,
  input  logic [INSTR_W-1:0] dc_lsu_instr_in,
  input  logic [INSTR_W-1:0] dc_bru_instr_in,
  output logic               dc_ready_out,
  output logic               ex_valid_out,
  output logic [INSTR_W-1:0] ex_ixu1_instr_out,
  output logic [INSTR_W-1:0] ex_ixu2_instr_out,
  output logic [INSTR_W-1:0] ex_lsu_instr_out,
  output logic [INSTR_W-1:0] ex_bru_instr_out,
  output logic [4:0]         lsu_ex_rd_out,
  output logic               lsu_ex_is_load_out,
  input  logic               stall_cnt_clr_in,
  output logic [CNT_W-1:0]   stall_cnt_out
);

  localparam logic [6:0] OPC_LOAD = 7'b0000011;

  function automatic logic is_load_op(input logic [INSTR_W-1:0] instr);
    return (instr[6:0] == OPC_LOAD);
  endfunction

  logic               ex_valid_r;
  logic [INSTR_W-1:0] ex_ixu1_r;
  logic [INSTR_W-1:0] ex_ixu2_r;
  logic [INSTR_W-1:0] ex_lsu_r;
  logic [INSTR_W-1:0] ex_bru_r;
  logic [CNT_W-1:0]   stall_cnt_r;

  logic capture_s;
  logic stall_cnt_inc_s;
  logic stall_cnt_sat_s;

  // Handshake and capture/increment qualifiers; a flush overrides a stall.
  always_comb begin
    dc_ready_out    = !stall_in || flush_in;
    capture_s       = !stall_in && !flush_in && dc_valid_in;
    stall_cnt_inc_s = stall_in && !flush_in;
    stall_cnt_sat_s = &stall_cnt_r;
  end

  // Execute bundle register: it captures the decode bundle or loads a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_r <= 1'b0;
      ex_ixu1_r  <= NOP_INSTR;
      ex_ixu2_r  <= NOP_INSTR;
      ex_lsu_r   <= NOP_INSTR;
      ex_bru_r   <= NOP_INSTR;
    end else if (capture_s) begin
      ex_valid_r <= 1'b1;
      ex_ixu1_r  <= dc_ixu1_instr_in;
      ex_ixu2_r  <= dc_ixu2_instr_in;
      ex_lsu_r   <= dc_lsu_instr_in;
      ex_bru_r   <= dc_bru_instr_in;
    end else begin
      ex_valid_r <= 1'b0;
      ex_ixu1_r  <= NOP_INSTR;
      ex_ixu2_r  <= NOP_INSTR;
      ex_lsu_r   <= NOP_INSTR;
      ex_bru_r   <= NOP_INSTR;
    end
  end

  // Stall counter: a clear wins over an increment, and the count holds at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (stall_cnt_clr_in) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (stall_cnt_inc_s && !stall_cnt_sat_s) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  // Register-to-port mapping and the LSU hazard taps.
  always_comb begin
    ex_valid_out       = ex_valid_r;
    ex_ixu1_instr_out  = ex_ixu1_r;
    ex_ixu2_instr_out  = ex_ixu2_r;
    ex_lsu_instr_out   = ex_lsu_r;
    ex_bru_instr_out   = ex_bru_r;
    stall_cnt_out      = stall_cnt_r;
    lsu_ex_rd_out      = ex_lsu_r[11:7];
    lsu_ex_is_load_out = ex_valid_r && is_load_op(ex_lsu_r);
  end

endmodule

// File: tb/tb_dc_ex_issue_reg.sv
// Self-checking bench for dc_ex_issue_reg: directed scenarios, then randomized cycles
// compared against a bundle-level reference model (a 16-bit counter and a 4-bit counter).
module tb_dc_ex_issue_reg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, stall_in, flush_in, dc_valid_in, stall_cnt_clr_in;
  logic [31:0] ixu1_in, ixu2_in, lsu_in, bru_in;

  logic        dc_ready_out, ex_valid_out, lsu_ex_is_load_out;
  logic [31:0] ex_ixu1, ex_ixu2, ex_lsu, ex_bru;
  logic [4:0]  lsu_ex_rd_out;
  logic [15:0] stall_cnt_out;

  logic        b_ready, b_valid, b_is_load;
  logic [31:0] b_ixu1, b_ixu2, b_lsu, b_bru;
  logic [4:0]  b_rd;
  logic [3:0]  b_cnt;

  int checks = 0;
  int errors = 0;

  // Reference state
  logic        m_valid;
  logic [31:0] m_slot [4];
  int          m_cnt16, m_cnt4;

  always #5 clk = ~clk;

  dc_ex_issue_reg dut (
    .clk(clk), .rst(rst), .stall_in(stall_in), .flush_in(flush_in),
    .dc_valid_in(dc_valid_in),
    .dc_ixu1_instr_in(ixu1_in), .dc_ixu2_instr_in(ixu2_in),
    .dc_lsu_instr_in(lsu_in), .dc_bru_instr_in(bru_in),
    .dc_ready_out(dc_ready_out), .ex_valid_out(ex_valid_out),
    .ex_ixu1_instr_out(ex_ixu1), .ex_ixu2_instr_out(ex_ixu2),
    .ex_lsu_instr_out(ex_lsu), .ex_bru_instr_out(ex_bru),
    .lsu_ex_rd_out(lsu_ex_rd_out), .lsu_ex_is_load_out(lsu_ex_is_load_out),
    .stall_cnt_clr_in(stall_cnt_clr_in), .stall_cnt_out(stall_cnt_out)
  );

  dc_ex_issue_reg #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .stall_in(stall_in), .flush_in(flush_in),
    .dc_valid_in(dc_valid_in),
    .dc_ixu1_instr_in(ixu1_in), .dc_ixu2_instr_in(ixu2_in),
    .dc_lsu_instr_in(lsu_in), .dc_bru_instr_in(bru_in),
    .dc_ready_out(b_ready), .ex_valid_out(b_valid),
    .ex_ixu1_instr_out(b_ixu1), .ex_ixu2_instr_out(b_ixu2),
    .ex_lsu_instr_out(b_lsu), .ex_bru_instr_out(b_bru),
    .lsu_ex_rd_out(b_rd), .lsu_ex_is_load_out(b_is_load),
    .stall_cnt_clr_in(stall_cnt_clr_in), .stall_cnt_out(b_cnt)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock of the reference model, written from the bundle rules.
  task automatic model_clock();
    logic issue;
    if (rst) begin
      m_valid = 1'b0;
      foreach (m_slot[k]) m_slot[k] = NOP;
      m_cnt16 = 0;
      m_cnt4  = 0;
    end else begin
      issue = dc_valid_in && !stall_in && !flush_in;
      m_valid   = issue;
      m_slot[0] = issue ? ixu1_in : NOP;
      m_slot[1] = issue ? ixu2_in : NOP;
      m_slot[2] = issue ? lsu_in  : NOP;
      m_slot[3] = issue ? bru_in  : NOP;
      if (stall_cnt_clr_in) begin
        m_cnt16 = 0;
        m_cnt4  = 0;
      end else if (stall_in && !flush_in) begin
        if (m_cnt16 < 65535) m_cnt16 = m_cnt16 + 1;
        if (m_cnt4  < 15)    m_cnt4  = m_cnt4 + 1;
      end
    end
  endtask

  task automatic compare_all();
    check_eq("ex_valid", ex_valid_out, m_valid);
    check_eq("ixu1", ex_ixu1, m_slot[0]);
    check_eq("ixu2", ex_ixu2, m_slot[1]);
    check_eq("lsu",  ex_lsu,  m_slot[2]);
    check_eq("bru",  ex_bru,  m_slot[3]);
    check_eq("lsu_rd", lsu_ex_rd_out, m_slot[2][11:7]);
    check_eq("is_load", lsu_ex_is_load_out, m_valid && (m_slot[2][6:0] == 7'b0000011));
    check_eq("cnt16", stall_cnt_out, m_cnt16);
    check_eq("cnt4", b_cnt, m_cnt4);
    check_eq("b_valid", b_valid, m_valid);
    check_eq("b_lsu", b_lsu, m_slot[2]);
  endtask

  // Drives one cycle of inputs, checks the ready handshake, clocks and checks state.
  task automatic step(input logic r, input logic st, input logic fl, input logic v,
                      input logic clr, input logic [31:0] i1, input logic [31:0] i2,
                      input logic [31:0] ls, input logic [31:0] br);
    rst = r; stall_in = st; flush_in = fl; dc_valid_in = v; stall_cnt_clr_in = clr;
    ixu1_in = i1; ixu2_in = i2; lsu_in = ls; bru_in = br;
    #1;
    check_eq("dc_ready", dc_ready_out, !st || fl);
    check_eq("b_ready", b_ready, !st || fl);
    @(posedge clk);
    model_clock();
    #1;
    compare_all();
  endtask

  initial begin
    logic [31:0] r1, r2, r3, r4;
    rst = 1'b1; stall_in = 1'b0; flush_in = 1'b0; dc_valid_in = 1'b0;
    stall_cnt_clr_in = 1'b0;
    ixu1_in = 32'h0; ixu2_in = 32'h0; lsu_in = 32'h0; bru_in = 32'h0;
    m_valid = 1'b0;
    foreach (m_slot[k]) m_slot[k] = NOP;
    m_cnt16 = 0; m_cnt4 = 0;

    // Reset held for two cycles with a stall request and a valid bundle pending
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444);
    check_eq("rst_valid", ex_valid_out, 1'b0);
    check_eq("rst_ixu1", ex_ixu1, 32'h0000_0013);
    check_eq("rst_bru", ex_bru, 32'h0000_0013);
    check_eq("rst_cnt", stall_cnt_out, 16'd0);
    check_eq("rst_is_load", lsu_ex_is_load_out, 1'b0);

    // Advance with lw x5
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0052_8333, 32'h0000_0093, 32'h0000_A283, 32'h0000_0063);
    check_eq("adv_valid", ex_valid_out, 1'b1);
    check_eq("adv_rd", lsu_ex_rd_out, 5'd5);
    check_eq("adv_is_load", lsu_ex_is_load_out, 1'b1);

    // Load-use stall for one cycle, then the held bundle issues
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0052_8333, 32'h0, 32'h0, 32'h0);
    check_eq("lu_bubble", ex_valid_out, 1'b0);
    check_eq("lu_cnt", stall_cnt_out, 16'd1);
    check_eq("lu_rd", lsu_ex_rd_out, 5'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0052_8333, 32'h0, 32'h0, 32'h0);
    check_eq("lu_issue", ex_ixu1, 32'h0052_8333);

    // Flush together with stall: ready stays high and the counter holds
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h1, 32'h2, 32'h3);
    check_eq("fl_valid", ex_valid_out, 1'b0);
    check_eq("fl_cnt", stall_cnt_out, 16'd1);

    // Saturation of the 4-bit counter, then a clear beating a same-cycle increment
    for (int i = 0; i < 20; i++)
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h5, 32'h6, 32'h7, 32'h8);
    check_eq("sat4", b_cnt, 4'hF);
    check_eq("cnt16_21", stall_cnt_out, 16'd21);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h5, 32'h6, 32'h7, 32'h8);
    check_eq("clr4", b_cnt, 4'h0);
    check_eq("clr16", stall_cnt_out, 16'd0);

    // Reset in the middle of a stall sequence
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'hA, 32'hB, 32'hC, 32'hD);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'hA, 32'hB, 32'hC, 32'hD);
    check_eq("mid_rst_cnt", stall_cnt_out, 16'd0);
    check_eq("mid_rst_lsu", ex_lsu, 32'h0000_0013);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hA, 32'hB, 32'hC, 32'hD);
    check_eq("post_rst_valid", ex_valid_out, 1'b1);
    check_eq("post_rst_ixu2", ex_ixu2, 32'h0000_000B);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      r1 = $urandom; r2 = $urandom; r3 = $urandom; r4 = $urandom;
      if ($urandom_range(0, 1) == 0) r3[6:0] = 7'b0000011;
      step(($urandom_range(0, 31) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 15) == 0), r1, r2, r3, r4);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
